// File: rtl/xc_aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xc_aes_pkg : GF(2^8) constants, coefficient sets, FSM states, helpers |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package xc_aes_pkg;

  localparam logic [7:0]  GF_POLY  = 8'h1b;
  // Nibble i holds the coefficient applied to column byte i.
  localparam logic [15:0] ENC_COEF = 16'h1132;
  localparam logic [15:0] DEC_COEF = 16'h9dbe;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mulk(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] r;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xc_gf_dot4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xc_gf_dot4 : 4-term GF(2^8) dot product of a column and coefficients  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module xc_gf_dot4
  import xc_aes_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic [15:0] i_coef,
  output logic [7:0]  o_dot
);

  always_comb begin
    o_dot = 8'h00;
    for (int i = 0; i < 4; i++) begin
      o_dot = o_dot ^ gf_mulk(i_col[8*i +: 8], i_coef[4*i +: 4]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/xc_aesmix_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xc_aesmix_iter : iterative (Inv)MixColumns, one output byte per cycle |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module xc_aesmix_iter
  import xc_aes_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [31:0] col_q,   col_d;
  logic [31:0] acc_q,   acc_d;
  logic        mode_q,  mode_d;

  logic [15:0] w_coef;
  logic [7:0]  w_byte;

  assign w_coef = mode_q ? ENC_COEF : DEC_COEF;

  xc_gf_dot4 u_dot (
    .i_col  (col_q),
    .i_coef (w_coef),
    .o_dot  (w_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          col_d   = rs1;
          mode_d  = enc;
          cnt_d   = 2'd0;
          acc_d   = 32'h0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!valid) begin
          cnt_d   = 2'd0;
          acc_d   = 32'h0;
          col_d   = 32'h0;
          state_d = IDLE;
        end else begin
          // Rotating the column lets the same coefficient wiring yield every row.
          acc_d = {w_byte, acc_q[31:8]};
          col_d = {col_q[7:0], col_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      col_q   <= 32'h0;
      acc_q   <= 32'h0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
    end
  end

  // Masked so the value can be OR-merged onto a shared result bus.
  assign ready  = (state_q == DONE);
  assign result = acc_q & {32{ready}};

endmodule
`default_nettype wire

// File: tb/tb_xc_aesmix_iter.sv
`default_nettype none
// Directed, table-driven bench for xc_aesmix_iter.
module tb_xc_aesmix_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] rs1;
  logic        enc;
  logic        ready;
  logic [31:0] result;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic        e;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clock = ~clock;

  xc_aesmix_iter dut (
    .clock  (clock),
    .reset  (reset),
    .valid  (valid),
    .rs1    (rs1),
    .enc    (enc),
    .ready  (ready),
    .result (result)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ready,result=%h required %h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; checks every cycle T+1..T+6.
  task automatic run_op(input string tag, input logic [31:0] a, input logic e, input logic [31:0] exp);
    valid = 1'b1;
    rs1   = a;
    enc   = e;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 5) begin
        chk($sformatf("%s cyc%0d", tag, k), {ready, result}, {1'b1, exp});
        valid = 1'b0;
      end else begin
        chk($sformatf("%s cyc%0d", tag, k), {ready, result}, 33'h0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'h455313db, 1'b1, 32'hbca14d8e};
    vecs[1] = '{32'hbca14d8e, 1'b0, 32'h455313db};
    vecs[2] = '{32'h9d58dc9f, 1'b0, 32'h5c220af2};
    vecs[3] = '{32'h01010101, 1'b1, 32'h01010101};
    vecs[4] = '{32'h01010101, 1'b0, 32'h01010101};
    vecs[5] = '{32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6};
    vecs[6] = '{32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6};
    vecs[7] = '{32'h5c220af2, 1'b1, 32'h9d58dc9f};

    reset = 1'b0;
    valid = 1'b0;
    rs1   = 32'h0;
    enc   = 1'b0;
    #1;
    chk("reset_state", {ready, result}, 33'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset", {ready, result}, 33'h0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].e, vecs[i].exp);
    end

    // Back-to-back: valid held high, second request taken one cycle after ready.
    valid = 1'b1;
    rs1   = 32'h455313db;
    enc   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 5) begin
        chk($sformatf("b2b cyc%0d", k), {ready, result}, {1'b1, 32'hbca14d8e});
        rs1 = 32'hbca14d8e;
        enc = 1'b0;
      end else if (k == 11) begin
        chk($sformatf("b2b cyc%0d", k), {ready, result}, {1'b1, 32'h455313db});
        valid = 1'b0;
      end else begin
        chk($sformatf("b2b cyc%0d", k), {ready, result}, 33'h0);
      end
    end

    // Abort: valid drops in the second BUSY cycle.
    valid = 1'b1;
    rs1   = 32'h455313db;
    enc   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("abort cyc%0d", k), {ready, result}, 33'h0);
      if (k == 2) valid = 1'b0;
    end
    run_op("reissue", 32'h5c220af2, 1'b1, 32'h9d58dc9f);

    // Asynchronous reset during BUSY.
    valid = 1'b1;
    rs1   = 32'h455313db;
    enc   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy async", {ready, result}, 33'h0);
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("rst_busy idle cyc%0d", k), {ready, result}, 33'h0);
    end
    run_op("after_rst_busy", 32'h01010101, 1'b1, 32'h01010101);

    // Asynchronous reset while the result is being presented.
    valid = 1'b1;
    rs1   = 32'hc6c6c6c6;
    enc   = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_done pre", {ready, result}, {1'b1, 32'hc6c6c6c6});
    reset = 1'b0;
    #1;
    chk("rst_done async", {ready, result}, 33'h0);
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_done idle", {ready, result}, 33'h0);
    run_op("after_rst_done", 32'h01010101, 1'b0, 32'h01010101);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
